// File: rtl/result_display.sv
// result_display
//   Captures a 16-bit ALU result and its flags on a one-cycle strobe. The
//   word is shown as four hex digits on a time-multiplexed, active-low
//   7-segment display, and the flags are mirrored to LEDs. A new result is
//   held pending and is committed only at a scan-frame boundary, which is the
//   tick that ends the digit-3 slot. No frame ever mixes old and new digits.
//
//   Optional build macro: RESULT_DISPLAY_BLANK_EN
//     When defined, leading zeros are suppressed. Digit 0 is always shown.
//     When undefined, all four digits are always driven.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   capture      one-cycle strobe that samples Z and flags
//   Z[15:0]      datapath result
//   flags[4:0]   datapath flags
//   ready        high while no result is pending
//   seg7[6:0]    segments {g,f,e,d,c,b,a}, active-low, registered
//   select[3:0]  digit enables, active-low one-hot; select[0] is the rightmost digit
//   flags_shown  flags committed together with the displayed value
//
// state | meaning
// ------+-------------------------------------------------------------
// BLANK | nothing committed since reset; all digits are off
// SHOW  | show_z is scanned onto the display; left only by reset
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic [15:0] Z,
    input  logic [4:0]  flags,
    output logic        ready,
    output logic [6:0]  seg7,
    output logic [3:0]  select,
    output logic [4:0]  flags_shown
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]         digit_q, digit_d;
    logic               pend_q, pend_d;
    logic [15:0]        pend_z_q, pend_z_d;
    logic [4:0]         pend_f_q, pend_f_d;
    logic [15:0]        show_z_q, show_z_d;
    logic [4:0]         show_f_q, show_f_d;
    logic [6:0]         seg7_q, seg7_d;
    logic [3:0]         select_q, select_d;

    logic               tick;
    logic               frame;
    logic               commit;
    logic [3:0]         nibble;
    logic               digit_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick   = (div_cnt_q == CNT_LAST);
    assign frame  = tick && (digit_q == 2'd3);
    assign commit = frame && (capture || pend_q);

    // Scan counters and capture/commit datapath.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
        digit_d   = tick ? digit_q + 2'd1 : digit_q;
        pend_d    = pend_q;
        pend_z_d  = pend_z_q;
        pend_f_d  = pend_f_q;
        show_z_d  = show_z_q;
        show_f_d  = show_f_q;
        if (frame) begin
            // A capture landing on the boundary bypasses the pending slot.
            if (capture) begin
                show_z_d = Z;
                show_f_d = flags;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                show_z_d = pend_z_q;
                show_f_d = pend_f_q;
                pend_d   = 1'b0;
            end
        end else if (capture) begin
            pend_z_d = Z;
            pend_f_d = flags;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            digit_q   <= 2'd0;
            pend_q    <= 1'b0;
            pend_z_q  <= 16'h0000;
            pend_f_q  <= 5'h00;
            show_z_q  <= 16'h0000;
            show_f_q  <= 5'h00;
        end else begin
            div_cnt_q <= div_cnt_d;
            digit_q   <= digit_d;
            pend_q    <= pend_d;
            pend_z_q  <= pend_z_d;
            pend_f_q  <= pend_f_d;
            show_z_q  <= show_z_d;
            show_f_q  <= show_f_d;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (commit) begin
            state_d = SHOW;
        end
    end

    // FSM: outputs (registered below).
    always_comb begin
        case (digit_q)
            2'd0:    nibble = show_z_q[3:0];
            2'd1:    nibble = show_z_q[7:4];
            2'd2:    nibble = show_z_q[11:8];
            default: nibble = show_z_q[15:12];
        endcase

`ifdef RESULT_DISPLAY_BLANK_EN
        // A digit is a leading zero when it and every digit to its left are zero.
        case (digit_q)
            2'd1:    digit_blank = (show_z_q[15:4] == 12'h000);
            2'd2:    digit_blank = (show_z_q[15:8] == 8'h00);
            2'd3:    digit_blank = (show_z_q[15:12] == 4'h0);
            default: digit_blank = 1'b0;
        endcase
`else
        digit_blank = 1'b0;
`endif

        seg7_d   = 7'h7F;
        select_d = 4'hF;
        if (state_q == SHOW && !digit_blank) begin
            select_d = ~(4'b0001 << digit_q);
            seg7_d   = hex7(nibble);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg7_q   <= 7'h7F;
            select_q <= 4'hF;
        end else begin
            seg7_q   <= seg7_d;
            select_q <= select_d;
        end
    end

    assign ready       = !pend_q;
    assign seg7        = seg7_q;
    assign select      = select_q;
    assign flags_shown = show_f_q;

endmodule

// File: doc/result_display.md
# result_display

Output-side consumer of the ALU datapath. It captures a 16-bit result `Z` and its 5-bit `flags` when strobed by the controlling FSM. The captured word is shown as four hex digits on a time-multiplexed, active-low 7-segment display, and the flags are mirrored to LEDs. New results are held pending and committed only at a scan-frame boundary, so no digit ever shows a mix of old and new values.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot. Legal range is 2..2^20.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `capture`  in  1  one-cycle strobe; samples `Z` and `flags` in that cycle.
- `Z`  in  16  datapath result.
- `flags`  in  5  datapath flags.
- `ready`  out  1  high when no result is pending.
- `seg7`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `select`  out  4  digit enables, active-low one-hot, registered. `select[0]` is the rightmost digit.
- `flags_shown`  out  5  flags committed together with the displayed value, registered.

## Operation
- **Registers**
  - `div_cnt`: REFRESH_DIV-range counter.
  - `digit`: 2-bit counter.
  - `pend_z`/`pend_f` with a `pend` bit.
  - `show_z`/`show_f`.
  - `state` ∈ {BLANK, SHOW}.
- **Tick:** `div_cnt` counts 0..REFRESH_DIV-1 and wraps to 0. `tick` is asserted in the cycle where `div_cnt == REFRESH_DIV-1`. On `tick`, `digit` advances 0→1→2→3→0.
- **Frame boundary:** a `tick` with `digit == 3`.
- **Capture:**
  - `capture` loads `Z`/`flags` into `pend_*` and sets `pend`.
  - A capture while `pend` is already set overwrites it; the latest value wins, and nothing is counted or reported.
- **Commit at the frame boundary:**
  - With `capture` in the same cycle: the incoming `Z`/`flags` go directly to `show_*`, and `pend` is cleared.
  - Otherwise, if `pend` is set: `pend_*` → `show_*`, and `pend` is cleared.
  - Any commit moves `state` to SHOW. There is no other transition; SHOW is left only by reset.
- **`ready`:** equals `!pend`, combinational from the register.
- **BLANK state:** `select = 4'b1111` and `seg7 = 7'h7F`. The scan counters keep running.
- **SHOW state:**
  - `select = ~(4'b0001 << digit)`.
  - `seg7` is the decode of nibble `show_z[4*digit+3 : 4*digit]`.
- **Hex decode (active-low):**
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- **Reset values:**
  - `div_cnt=0`, `digit=0`, `pend=0`, `show_*=0`, `state=BLANK`.
  - `seg7=7'h7F`, `select=4'hF`, `flags_shown=0`, `ready=1`.
  - Reset asserted mid-frame discards pending and shown data immediately.

## Timing
- `seg7`/`select` are registered from `digit`/`state`/`show_z`. They reflect a `digit` change one cycle after the `tick` edge.
- **Capture-to-display latency:**
  - Minimum 2 cycles, when the capture coincides with a frame boundary.
  - Maximum 4·REFRESH_DIV + 1 cycles.
- `flags_shown` updates in the same cycle as `show_f`, one cycle after the commit edge.
- `ready` falls the cycle after `capture` and rises the cycle after the commit.
- `capture` is level-sampled every cycle. Holding it high N cycles equals N captures; the last one wins.

## Configuration
- `RESULT_DISPLAY_BLANK_EN`
  - **Defined:** leading-zero suppression in SHOW. A digit `d > 0` is blanked (its `select` bit high, `seg7=7'h7F`) when every nibble at position ≥ d is zero. Digit 0 is always shown, so 0x0000 displays a single "0".
  - **Undefined:** all four digits are always driven.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset:** release `reset` → `seg7=7F`, `select=F`, `ready=1` through 32 cycles with no capture.
- **Single capture:** `capture` with `Z=16'h1A3F`, `flags=5'b10010`. After the next frame boundary, the successive digit slots show:

  | `select` | `seg7` |
  |---|---|
  | E | 0E |
  | D | 30 |
  | B | 08 |
  | 7 | 79 |

  `flags_shown=12`, and `ready` returns to 1.
- **Overwrite while pending:** capture 16'h1111, then 16'h2222 before the boundary → only 2222 (digit code 24) ever appears. `ready` stays 0 until the commit.
- **Capture on boundary cycle:** capture 16'hBEEF exactly when `tick && digit==3` → the next digit 0 slot shows F (0E). `ready` stays 1 the cycle after.
- **Mid-scan reset:** assert `reset` low while SHOW with `pend=1` → next cycle `seg7=7F`, `select=F`, `ready=1`, `state` BLANK.
- **Leading-zero suppression:** with `RESULT_DISPLAY_BLANK_EN` defined, capture 16'h0042 → digits 3 and 2 have `select` high and `seg7=7F`; digit 1 shows 19 and digit 0 shows 24.
